// File: rtl/ff_pkg.sv
// Shared defaults for the ff register and the counter blocks built on it.
package ff_pkg;

    localparam int DEFAULT_BITS = 1;
    localparam int MAX_BITS = 32;
    localparam logic [MAX_BITS-1:0] DEFAULT_RST_VAL = '0;

endpackage

// File: rtl/ff_bit.sv
// Single-bit flop with synchronous active-low reset and load enable.
module ff_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    input  logic D,
    output logic Q
);

    // Reset outranks the enable, so a load never wins against a reset edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Q <= RST_VAL;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/ff.sv
// BITS-wide enabled register assembled from independent ff_bit cells.
module ff
    import ff_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS,
    parameter logic [BITS-1:0] RST_VAL = DEFAULT_RST_VAL[BITS-1:0]
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic [BITS-1:0] D,
    output logic [BITS-1:0] Q
);

    // Each bit only sees its own data and reset bit plus the shared controls.
    for (genvar i = 0; i < BITS; i++) begin : g_bit
        ff_bit #(
            .RST_VAL(RST_VAL[i])
        ) u_bit (
            .CLK  (CLK),
            .RST_N(RST_N),
            .EN   (EN),
            .D    (D[i]),
            .Q    (Q[i])
        );
    end

endmodule

// File: tb/tb_ff.sv
// Scoreboard bench for ff at widths 1, 4 (two reset values) and 16.
module tb_ff;

    localparam logic [3:0]  RV4A = 4'b0000;
    localparam logic [3:0]  RV4B = 4'b0101;
    localparam logic [15:0] RV16 = 16'hA5C3;

    typedef struct {
        logic        q1;
        logic [3:0]  q4a;
        logic [3:0]  q4b;
        logic [15:0] q16;
    } exp_t;

    logic        CLK;
    logic        rst_n;
    logic        en;
    logic [15:0] d;
    logic        q1;
    logic [3:0]  q4a;
    logic [3:0]  q4b;
    logic [15:0] q16;

    exp_t scoreboard[$];
    exp_t model;
    int   checks;
    int   errors;

    ff u_ff1 (
        .CLK  (CLK),
        .RST_N(rst_n),
        .EN   (en),
        .D    (d[0:0]),
        .Q    (q1)
    );

    ff #(.BITS(4), .RST_VAL(RV4A)) u_ff4a (
        .CLK  (CLK),
        .RST_N(rst_n),
        .EN   (en),
        .D    (d[3:0]),
        .Q    (q4a)
    );

    ff #(.BITS(4), .RST_VAL(RV4B)) u_ff4b (
        .CLK  (CLK),
        .RST_N(rst_n),
        .EN   (en),
        .D    (d[3:0]),
        .Q    (q4b)
    );

    ff #(.BITS(16), .RST_VAL(RV16)) u_ff16 (
        .CLK  (CLK),
        .RST_N(rst_n),
        .EN   (en),
        .D    (d),
        .Q    (q16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [15:0] d_v);
        @(negedge CLK);
        rst_n = rst_v;
        en    = en_v;
        d     = d_v;
        if (!rst_v) begin
            model.q1  = 1'b0;
            model.q4a = RV4A;
            model.q4b = RV4B;
            model.q16 = RV16;
        end else if (en_v) begin
            model.q1  = d_v[0];
            model.q4a = d_v[3:0];
            model.q4b = d_v[3:0];
            model.q16 = d_v;
        end
        scoreboard.push_back(model);
    endtask

    task automatic checkOutput(input string tag);
        exp_t exp_v;
        @(posedge CLK);
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s: scoreboard empty, observed none expected one entry", tag);
        end else begin
            exp_v = scoreboard.pop_front();
            check_value({tag, ".q1"},  {31'd0, q1},  {31'd0, exp_v.q1});
            check_value({tag, ".q4a"}, {28'd0, q4a}, {28'd0, exp_v.q4a});
            check_value({tag, ".q4b"}, {28'd0, q4b}, {28'd0, exp_v.q4b});
            check_value({tag, ".q16"}, {16'd0, q16}, {16'd0, exp_v.q16});
        end
    endtask

    initial begin
        exp_t prev;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        en     = 1'b0;
        d      = '0;
        model  = '{q1: 1'bx, q4a: 4'bx, q4b: 4'bx, q16: 16'bx};

        $display("[TB] reset with load enabled");
        applyStimulus(1'b0, 1'b1, 16'h000A);
        checkOutput("reset");

        $display("[TB] load 0110, nothing visible before the edge");
        prev = model;
        applyStimulus(1'b1, 1'b1, 16'h0006);
        #1;
        check_value("load_pre_edge", {28'd0, q4a}, {28'd0, prev.q4a});
        checkOutput("load");

        $display("[TB] hold with EN low and D all ones");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'hFFFF);
            checkOutput("hold");
        end
        check_value("hold_q4a_literal", {28'd0, q4a}, 32'h6);

        $display("[TB] reset beats enable, then load resumes");
        applyStimulus(1'b0, 1'b1, 16'hFFFF);
        checkOutput("priority_reset");
        applyStimulus(1'b1, 1'b1, 16'hFFFF);
        checkOutput("priority_release");

        $display("[TB] reset glitch between edges while EN low");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        #1 rst_n = 1'b0;
        #1;
        check_value("glitch_mid_cycle_q1", {31'd0, q1}, {31'd0, model.q1});
        check_value("glitch_mid_cycle_q16", {16'd0, q16}, {16'd0, model.q16});
        rst_n = 1'b1;
        checkOutput("glitch_next_edge");

        $display("[TB] random sweep");
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                          16'($urandom));
            checkOutput("sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
